// File: rtl/curl_pow_multi.sv
// curl_pow_multi: multi-unit Curl-P transform engine with parallel proof-of-work nonce search
module curl_pow_multi #(
  parameter int CU_NUM = 4,
  parameter int NUMBER_OF_ROUNDS = 81,
  parameter int MWM_MASK_WIDTH = 32,
  parameter int ITER_WIDTH = 32,
  parameter int UNIT_BASE = 0,
  localparam int IW = (CU_NUM > 1) ? $clog2(CU_NUM) : 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_we,
  input  logic [3:0]                i_addr,
  input  logic [53:0]               i_data,
  input  logic                      i_transform,
  input  logic                      i_pow,
  input  logic                      i_abort,
  input  logic [MWM_MASK_WIDTH-1:0] i_mwm_mask,
  input  logic [ITER_WIDTH-1:0]     i_max_iter,
  output logic                      o_busy,
  output logic                      o_transforming,
  output logic                      o_pow_hash_finish,
  output logic                      o_pow_finish,
  output logic                      o_pow_timeout,
  output logic [IW-1:0]             o_unit_idx,
  output logic [ITER_WIDTH-1:0]     o_iter_cnt,
  output logic [161:0]              o_data
);
  localparam int RW = $clog2(NUMBER_OF_ROUNDS + 1);
  typedef enum logic [2:0] {IDLE, TRANSFORM, POW, CHECK, LOAD, DONE} state_t;
  state_t state, state_nxt;
  logic [CU_NUM-1:0][1457:0] st, nxt;
  logic [CU_NUM-1:0][161:0] nonce;
  logic [CU_NUM-1:0][53:0] lfsr, seed, lfsr_adv;
  logic [CU_NUM-1:0] valid;
  logic [323:0] mid_lo;
  logic [971:0] mid_hi;
  logic [MWM_MASK_WIDTH-1:0] mask;
  logic [ITER_WIDTH-1:0] limit;
  logic [RW-1:0] rc;
  logic [IW-1:0] sel;
  logic any_valid, last_rnd, limit_hit, start, abort_act, hash_done;

  // Curl S-box: result for sel = t1 + 3*t2 + 4 over balanced trits
  function automatic logic [1:0] tf(input logic [1:0] t1, input logic [1:0] t2);
    case ({t2, t1})
      4'b1111: return 2'b01;
      4'b1100: return 2'b00;
      4'b1101: return 2'b11;
      4'b0011: return 2'b01;
      4'b0000: return 2'b11;
      4'b0001: return 2'b00;
      4'b0111: return 2'b11;
      4'b0100: return 2'b01;
      4'b0101: return 2'b00;
      default: return 2'b00;
    endcase
  endfunction

  // balanced-ternary sum modulo 3
  function automatic logic [1:0] tadd(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'b00) ? b : (b == 2'b00) ? a : (a == b) ? {~a[1], 1'b1} : 2'b00;
  endfunction

  // 27 steps of the trit LFSR x[j+27] = x[j] + x[j+5]
  function automatic logic [53:0] step27(input logic [53:0] r);
    logic [53:0] v;
    v = r;
    for (int k = 0; k < 27; k++) v = {tadd(v[1:0], v[11:10]), v[53:2]};
    return v;
  endfunction

  for (genvar u = 0; u < CU_NUM; u++) begin : g_unit
    localparam logic [25:0] UN = 26'(UNIT_BASE + u);
    logic [MWM_MASK_WIDTH-1:0] hit;
    for (genvar i = 0; i < 729; i++) begin : g_trit
      localparam int A = 364 - i / 2;
      localparam int B = (i == 0) ? 0 : 728 - ((i % 2 == 1) ? i / 2 : i / 2 - 1);
      if (i % 2 == 1) begin : g_odd
        assign nxt[u][2*i+:2] = tf(st[u][2*A+:2], st[u][2*B+:2]);
      end else begin : g_even
        assign nxt[u][2*i+:2] = tf(st[u][2*B+:2], st[u][2*A+:2]);
      end
    end
    for (genvar k = 0; k < 27; k++) begin : g_seed
      if (k == 0) begin : g_one
        assign seed[u][1:0] = 2'b01;
      end else begin : g_bit
        assign seed[u][2*k+:2] = {1'b0, UN[k-1]};
      end
    end
    for (genvar m = 0; m < MWM_MASK_WIDTH; m++) begin : g_chk
      assign hit[m] = mask[m] & |st[u][2*(242-m)+:2];
    end
    assign valid[u] = ~|hit;
    assign lfsr_adv[u] = step27(lfsr[u]);
  end

  assign o_busy = state != IDLE;
  assign o_transforming = state == TRANSFORM;
  assign any_valid = |valid;
  assign last_rnd = rc == RW'(NUMBER_OF_ROUNDS - 1);
  assign limit_hit = limit != '0 && o_iter_cnt >= limit;
  assign start = state == IDLE && i_pow;
  assign abort_act = i_abort && (state == LOAD || state == POW || state == CHECK);
  assign hash_done = state == POW && last_rnd && !i_abort;

  // lowest-index valid unit wins
  always_comb begin
    sel = '0;
    for (int u = CU_NUM - 1; u >= 0; u--) sel = valid[u] ? IW'(u) : sel;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      state_nxt = i_pow ? LOAD : i_transform ? TRANSFORM : IDLE;
      TRANSFORM: state_nxt = last_rnd ? IDLE : TRANSFORM;
      LOAD:      state_nxt = i_abort ? DONE : POW;
      POW:       state_nxt = i_abort ? DONE : last_rnd ? CHECK : POW;
      CHECK:     state_nxt = (any_valid || i_abort || limit_hit) ? DONE : LOAD;
      default:   state_nxt = IDLE;
    endcase
  end

  // state register
  always_ff @(posedge i_clk) state <= i_rst ? IDLE : state_nxt;

  // unit states, nonces, search bookkeeping and result registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      st <= '0;
      nonce <= '0;
      lfsr <= seed;
      mid_lo <= '0;
      mid_hi <= '0;
      mask <= '0;
      limit <= '0;
      rc <= '0;
      o_pow_hash_finish <= 1'b0;
      o_pow_finish <= 1'b0;
      o_pow_timeout <= 1'b0;
      o_unit_idx <= '0;
      o_iter_cnt <= '0;
      o_data <= '0;
    end else begin
      rc <= ((state == TRANSFORM || state == POW) && !last_rnd) ? rc + 1'b1 : '0;
      o_pow_hash_finish <= hash_done;
      if (start) begin
        mid_lo <= st[0][323:0];
        mid_hi <= st[0][1457:486];
        mask <= i_mwm_mask;
        limit <= i_max_iter;
        o_iter_cnt <= '0;
        o_pow_finish <= 1'b0;
        o_pow_timeout <= 1'b0;
      end
      if (hash_done && !(&o_iter_cnt)) o_iter_cnt <= o_iter_cnt + 1'b1;
      if (state == CHECK && any_valid) begin
        o_pow_finish <= 1'b1;
        o_unit_idx <= sel;
        o_data <= nonce[sel];
      end else if ((state == CHECK && limit_hit) || abort_act) begin
        o_pow_timeout <= 1'b1;
      end
      for (int u = 0; u < CU_NUM; u++) begin
        if (state == LOAD) st[u] <= {mid_hi, nonce[u], mid_lo};
        else if (state == POW || (state == TRANSFORM && u == 0)) st[u] <= nxt[u];
        if (state == CHECK && !any_valid) begin
          nonce[u] <= {lfsr[u], nonce[u][161:54]};
          lfsr[u] <= lfsr_adv[u];
        end
      end
      if (state == IDLE && i_we && i_addr < 4'd9) st[0][i_addr*54+:54] <= i_data;
    end
  end
endmodule

// File: tb/tb_curl_pow_multi.sv
// tb_curl_pow_multi: directed + randomized checks of curl_pow_multi against a trit-level reference model
module tb_curl_pow_multi;
  logic clk, rst, we, transform, pow, abort;
  logic [3:0] addr;
  logic [53:0] data;
  logic [31:0] mwm_mask, max_iter;
  logic busy, transforming, hash_fin, pow_fin, pow_tmo;
  logic [1:0] unit_idx;
  logic [31:0] iter_cnt;
  logic [161:0] odata;
  int n_chk = 0, n_fail = 0;

  curl_pow_multi dut (
    .i_clk(clk), .i_rst(rst), .i_we(we), .i_addr(addr), .i_data(data),
    .i_transform(transform), .i_pow(pow), .i_abort(abort),
    .i_mwm_mask(mwm_mask), .i_max_iter(max_iter),
    .o_busy(busy), .o_transforming(transforming), .o_pow_hash_finish(hash_fin),
    .o_pow_finish(pow_fin), .o_pow_timeout(pow_tmo), .o_unit_idx(unit_idx),
    .o_iter_cnt(iter_cnt), .o_data(odata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int ttab[9] = '{1, 0, -1, 1, -1, 0, -1, 1, 0};
  int ms[729], cs[729], h0[729];
  int mn[4][81];
  int ml[4][27];

  function automatic logic [1:0] enc(input int t);
    return t == 1 ? 2'b01 : t == -1 ? 2'b11 : 2'b00;
  endfunction

  function automatic int bal(input int x);
    int y;
    y = ((x % 3) + 3) % 3;
    return y == 2 ? -1 : y;
  endfunction

  // Curl-P-81 over the index walk 0,364,728,363,727,...
  function automatic void curl_model();
    int t[729];
    int p, q;
    for (int r = 0; r < 81; r++) begin
      p = 0;
      for (int i = 0; i < 729; i++) begin
        q = p < 365 ? p + 364 : p - 365;
        t[i] = ttab[cs[p] + 3 * cs[q] + 4];
        p = q;
      end
      cs = t;
    end
  endfunction

  function automatic void hash_unit(input int u);
    cs = ms;
    for (int k = 0; k < 81; k++) cs[162+k] = mn[u][k];
    curl_model();
  endfunction

  function automatic bit mask_ok(input logic [31:0] m);
    for (int b = 0; b < 32; b++) if (m[b] && cs[242-b] != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void advance();
    int x[54];
    for (int u = 0; u < 4; u++) begin
      for (int j = 0; j < 27; j++) x[j] = ml[u][j];
      for (int j = 0; j < 27; j++) x[27+j] = bal(x[j] + x[j+5]);
      for (int k = 0; k < 54; k++) mn[u][k] = mn[u][k+27];
      for (int k = 0; k < 27; k++) mn[u][54+k] = ml[u][k];
      for (int j = 0; j < 27; j++) ml[u][j] = x[27+j];
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 729; i++) ms[i] = 0;
    for (int u = 0; u < 4; u++) begin
      for (int k = 0; k < 81; k++) mn[u][k] = 0;
      ml[u][0] = 1;
      for (int k = 1; k < 27; k++) ml[u][k] = (u >> (k - 1)) & 1;
    end
  endfunction

  task automatic model_pow(input logic [31:0] m, input int lim, output bit fin, output int idx,
                           output int iters, output logic [161:0] dat);
    int hitu;
    fin = 0; idx = 0; dat = '0;
    for (iters = 1; iters <= 10000; iters++) begin
      hitu = -1;
      for (int u = 3; u >= 0; u--) begin
        hash_unit(u);
        if (u == 0) h0 = cs;
        if (mask_ok(m)) hitu = u;
      end
      if (hitu >= 0) begin
        fin = 1; idx = hitu;
        for (int k = 0; k < 81; k++) dat[2*k+:2] = enc(mn[hitu][k]);
        ms = h0;
        return;
      end
      advance();
      if (lim != 0 && iters == lim) begin
        ms = h0;
        return;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_chk++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_state(input string tag);
    logic [1457:0] e;
    int d;
    logic [1:0] gt, et;
    for (int i = 0; i < 729; i++) e[2*i+:2] = enc(ms[i]);
    d = -1; gt = '0; et = '0;
    for (int i = 728; i >= 0; i--)
      if (dut.st[0][2*i+:2] !== e[2*i+:2]) begin d = i; gt = dut.st[0][2*i+:2]; et = e[2*i+:2]; end
    n_chk++;
    assert (dut.st[0] === e) else begin
      n_fail++;
      $error("FAIL %s first differing trit %0d got=%b exp=%b", tag, d, gt, et);
    end
  endtask

  task automatic write_words();
    logic [53:0] d;
    for (int w = 0; w < 9; w++) begin
      for (int k = 0; k < 27; k++) d[2*k+:2] = enc(ms[27*w+k]);
      we = 1; addr = 4'(w); data = d;
      tick();
    end
    we = 0;
  endtask

  task automatic randomize_words();
    for (int i = 0; i < 243; i++) ms[i] = int'($urandom_range(0, 2)) - 1;
  endtask

  task automatic run_transform(input string tag);
    int cnt;
    transform = 1;
    tick();
    transform = 0;
    cnt = 0;
    while (transforming && cnt < 200) begin cnt++; tick(); end
    check({tag, "_cycles"}, cnt, 81);
    cs = ms; curl_model(); ms = cs;
    check_state({tag, "_state"});
  endtask

  task automatic run_pow(input string tag, input logic [31:0] m, input int lim, input int bound,
                         output int pulses, output int fin_cyc, output bit xf_seen);
    int cyc;
    mwm_mask = m; max_iter = lim; pow = 1;
    tick();
    pow = 0; transform = 0;
    pulses = 0; fin_cyc = -1; cyc = 0; xf_seen = transforming;
    while (busy && cyc < bound) begin
      tick(); cyc++;
      if (hash_fin) pulses++;
      if (transforming) xf_seen = 1;
      if (pow_fin && fin_cyc < 0) fin_cyc = cyc;
    end
    check({tag, "_ends_idle"}, busy, 1'b0);
  endtask

  task automatic pow_and_check(input string tag, input logic [31:0] m, input int lim);
    bit fin, xf;
    int idx, iters, pulses, fc;
    logic [161:0] dat;
    model_pow(m, lim, fin, idx, iters, dat);
    run_pow(tag, m, lim, 84 * lim + 20, pulses, fc, xf);
    check({tag, "_finish"}, pow_fin, fin);
    check({tag, "_timeout"}, pow_tmo, !fin);
    check({tag, "_iter"}, iter_cnt, iters);
    check({tag, "_pulses"}, pulses, iters);
    if (fin) begin
      check({tag, "_idx"}, unit_idx, idx);
      check({tag, "_data"}, odata, dat);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_xf"}, transforming, 1'b0);
    check({tag, "_hashfin"}, hash_fin, 1'b0);
    check({tag, "_fin"}, pow_fin, 1'b0);
    check({tag, "_tmo"}, pow_tmo, 1'b0);
    check({tag, "_idx"}, unit_idx, 2'd0);
    check({tag, "_iter"}, iter_cnt, 32'd0);
    check({tag, "_data"}, odata, 162'd0);
  endtask

  initial begin
    bit fin, xf, found;
    int idx, iters, pulses, fc;
    logic [161:0] dat;
    logic [31:0] s, z0, z1, z2, z3;
    rst = 1; we = 0; addr = '0; data = '0; transform = 0; pow = 0; abort = 0;
    mwm_mask = '0; max_iter = '0;
    tick(); tick();
    rst = 0;
    model_reset();
    check_all_zero("reset");

    write_words();
    run_transform("xf_zero");

    randomize_words();
    write_words();
    for (int a = 9; a < 16; a++) begin
      we = 1; addr = 4'(a); data = {$urandom, $urandom};
      tick();
    end
    we = 0;
    run_transform("xf_rand");

    model_pow(32'd0, 0, fin, idx, iters, dat);
    transform = 1;
    run_pow("mask0", 32'd0, 0, 200, pulses, fc, xf);
    check("mask0_fin_cycle", fc, 83);
    check("mask0_no_xf", xf, 1'b0);
    check("mask0_finish", pow_fin, 1'b1);
    check("mask0_timeout", pow_tmo, 1'b0);
    check("mask0_idx", unit_idx, idx);
    check("mask0_iter", iter_cnt, 32'd1);
    check("mask0_data", odata, dat);

    model_pow(32'hffff_ffff, 3, fin, idx, iters, dat);
    run_pow("ones", 32'hffff_ffff, 3, 300, pulses, fc, xf);
    check("ones_pulses", pulses, 3);
    check("ones_timeout", pow_tmo, 1'b1);
    check("ones_finish", pow_fin, fin);
    check("ones_iter", iter_cnt, 32'd3);

    found = 0; s = '0;
    for (int t = 0; t < 50 && !found; t++) begin
      randomize_words();
      z0 = '0; z1 = '0; z2 = '0; z3 = '0;
      for (int u = 0; u < 4; u++) begin
        hash_unit(u);
        for (int b = 0; b < 32; b++) begin
          if (u == 0) z0[b] = cs[242-b] == 0;
          if (u == 1) z1[b] = cs[242-b] == 0;
          if (u == 2) z2[b] = cs[242-b] == 0;
          if (u == 3) z3[b] = cs[242-b] == 0;
        end
      end
      s = z1 & z3;
      found = s != 0 && (s & ~z0) != 0 && (s & ~z2) != 0;
    end
    write_words();
    model_pow(s, 1, fin, idx, iters, dat);
    run_pow("pair", s, 1, 200, pulses, fc, xf);
    check("pair_finish", pow_fin, fin);
    check("pair_idx", unit_idx, idx);
    check("pair_data", odata, dat);

    mwm_mask = 32'hffff_ffff; max_iter = 0; pow = 1;
    tick();
    pow = 0;
    repeat (40) tick();
    abort = 1;
    tick();
    abort = 0;
    check("abort_timeout", pow_tmo, 1'b1);
    check("abort_finish", pow_fin, 1'b0);
    tick();
    check("abort_idle", busy, 1'b0);

    mwm_mask = 32'hffff_ffff; max_iter = 0; pow = 1;
    tick();
    pow = 0;
    repeat (30) tick();
    rst = 1;
    tick();
    check_all_zero("midrst");
    rst = 0;
    model_reset();

    for (int r = 0; r < 5; r++) begin
      randomize_words();
      write_words();
      pow_and_check($sformatf("rand%0d", r),
                    (32'd1 << $urandom_range(0, 31)) | (32'd1 << $urandom_range(0, 31)), 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
